// File: rtl/led_pattern_pkg.sv
// Shared types and seed patterns for the LED pattern engine.
package led_pattern_pkg;

    // Widest LED bank the seed helper can describe.
    localparam int MAX_LED = 256;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_SHR    = 3'd0;
    localparam mode_t MODE_SHL    = 3'd1;
    localparam mode_t MODE_OUT    = 3'd2;
    localparam mode_t MODE_IN     = 3'd3;
    localparam mode_t MODE_BOUNCE = 3'd4;
    localparam mode_t MODE_BLINK  = 3'd5;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    // Starting pattern for each mode on an n-LED bank. The caller keeps
    // the low n bits; everything above bit n-1 is zero.
    function automatic logic [MAX_LED-1:0] seed(input mode_t mode, input int n);
        logic [MAX_LED-1:0] msb, lsb, mid, ones, s;
        for (int i = 0; i < MAX_LED; i++) begin
            msb[i]  = (i == n - 1);
            lsb[i]  = (i == 0);
            mid[i]  = (i == n / 2) || (i == n / 2 - 1);
            ones[i] = (i < n);
        end
        case (mode)
            MODE_SHR:    s = msb;
            MODE_SHL:    s = lsb;
            MODE_OUT:    s = mid;
            MODE_IN:     s = msb | lsb;
            MODE_BOUNCE: s = msb;
            MODE_BLINK:  s = ones;
            default:     s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_pattern_engine_tick.sv
// Prescaler, tick generation and step edge detection for the LED engine.
module led_tick_gen #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int RATE0_HZ = 1,
    parameter int RATE1_HZ = 2,
    parameter int RATE2_HZ = 5,
    parameter int RATE3_HZ = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       step,
    input  logic [1:0] speed,
    input  logic       restart,
    output logic       adv
);

    localparam int DIV0 = CLK_HZ / RATE0_HZ;
    localparam int DIV1 = CLK_HZ / RATE1_HZ;
    localparam int DIV2 = CLK_HZ / RATE2_HZ;
    localparam int DIV3 = CLK_HZ / RATE3_HZ;
    // RATE0 is the slowest rate, so its divisor sizes the counter.
    localparam int CW   = $clog2(DIV0);

    localparam logic [CW-1:0] TOP0 = CW'(DIV0 - 1);
    localparam logic [CW-1:0] TOP1 = CW'(DIV1 - 1);
    localparam logic [CW-1:0] TOP2 = CW'(DIV2 - 1);
    localparam logic [CW-1:0] TOP3 = CW'(DIV3 - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] top_sel;
    logic          step_q;
    logic          tick;
    logic          step_rise;

    // Terminal count for the selected rate.
    always_comb begin
        top_sel = TOP0;
        case (speed)
            2'd0: top_sel = TOP0;
            2'd1: top_sel = TOP1;
            2'd2: top_sel = TOP2;
            2'd3: top_sel = TOP3;
            default: top_sel = TOP0;
        endcase
    end

    // '>=' catches a count left above the new terminal after a speed change.
    assign tick      = en & (cnt >= top_sel);
    assign step_rise = step & ~step_q;
    assign adv       = tick | (~en & step_rise);

    // Prescaler: counts while running, holds while paused, restarts on mode change.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

    // Previous step level for rising edge detection.
    always_ff @(posedge clk) begin
        if (!rst)
            step_q <= 1'b0;
        else
            step_q <= step;
    end

endmodule

// File: rtl/led_pattern_engine.sv
// N-LED pattern sequencer: shift, in/out, bounce and blink patterns with a
// wrap strobe. Define LED_PWM_EN to add the bright port and PWM dimming.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int N_LED    = 16,
    parameter int CLK_HZ   = 100_000_000,
    parameter int RATE0_HZ = 1,
    parameter int RATE1_HZ = 2,
    parameter int RATE2_HZ = 5,
    parameter int RATE3_HZ = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step,
    input  logic [2:0]       mode,
    input  logic [1:0]       speed,
`ifdef LED_PWM_EN
    input  logic [3:0]       bright,
`endif
    output logic [N_LED-1:0] led,
    output logic             wrap
);

    localparam int HALF = N_LED / 2;

    localparam logic [N_LED-1:0] LSB = N_LED'(1);
    localparam logic [N_LED-1:0] MSB = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] MID = {{(HALF-1){1'b0}}, 2'b11, {(HALF-1){1'b0}}};

    logic [N_LED-1:0] pat;
    logic [N_LED-1:0] pat_nx;
    logic [N_LED-1:0] seed_now;
    logic [HALF-1:0]  up;
    logic [HALF-1:0]  lo;
    mode_t            mode_q;
    dir_t             dir;
    dir_t             dir_nx;
    logic             wrap_nx;
    logic             restart;
    logic             adv;

    assign restart  = (mode != mode_q);
    assign seed_now = N_LED'(seed(mode, N_LED));
    assign up       = pat[N_LED-1:HALF];
    assign lo       = pat[HALF-1:0];

    led_tick_gen #(
        .CLK_HZ   (CLK_HZ),
        .RATE0_HZ (RATE0_HZ),
        .RATE1_HZ (RATE1_HZ),
        .RATE2_HZ (RATE2_HZ),
        .RATE3_HZ (RATE3_HZ)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .step    (step),
        .speed   (speed),
        .restart (restart),
        .adv     (adv)
    );

    // Pattern successor for the latched mode, with reload and wrap detection.
    always_comb begin
        pat_nx  = pat;
        dir_nx  = dir;
        wrap_nx = 1'b0;
        case (mode_q)
            MODE_SHR: begin
                if (pat == LSB) begin
                    pat_nx  = MSB;
                    wrap_nx = 1'b1;
                end else begin
                    pat_nx  = pat >> 1;
                end
            end
            MODE_SHL: begin
                if (pat == MSB) begin
                    pat_nx  = LSB;
                    wrap_nx = 1'b1;
                end else begin
                    pat_nx  = pat << 1;
                end
            end
            MODE_OUT: begin
                if (pat == (MSB | LSB)) begin
                    pat_nx  = MID;
                    wrap_nx = 1'b1;
                end else begin
                    pat_nx  = {up << 1, lo >> 1};
                end
            end
            MODE_IN: begin
                if (pat == MID) begin
                    pat_nx  = MSB | LSB;
                    wrap_nx = 1'b1;
                end else begin
                    pat_nx  = {up >> 1, lo << 1};
                end
            end
            MODE_BOUNCE: begin
                // Turning at an end moves straight back, so neither end repeats.
                if (dir == DIR_RIGHT) begin
                    if (pat == LSB) begin
                        pat_nx = LSB << 1;
                        dir_nx = DIR_LEFT;
                    end else begin
                        pat_nx = pat >> 1;
                    end
                end else begin
                    if (pat == MSB) begin
                        pat_nx  = MSB >> 1;
                        dir_nx  = DIR_RIGHT;
                        wrap_nx = 1'b1;
                    end else begin
                        pat_nx  = pat << 1;
                    end
                end
            end
            MODE_BLINK: begin
                pat_nx  = ~pat;
                wrap_nx = (pat == '0);
            end
            default: begin
                pat_nx  = '0;
            end
        endcase
    end

    // Pattern state: reset and mode change reseed; otherwise advance on adv.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= mode;
            pat    <= seed_now;
            dir    <= DIR_RIGHT;
            wrap   <= 1'b0;
        end else if (restart) begin
            mode_q <= mode;
            pat    <= seed_now;
            dir    <= DIR_RIGHT;
            wrap   <= 1'b0;
        end else if (adv) begin
            pat    <= pat_nx;
            dir    <= dir_nx;
            wrap   <= wrap_nx;
        end else begin
            wrap   <= 1'b0;
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM phase; LEDs lit while the phase is below bright.
    always_ff @(posedge clk) begin
        if (!rst)
            pwm_cnt <= 4'd0;
        else
            pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign led = pat & {N_LED{pwm_cnt < bright}};
`else
    assign led = pat;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (CLK_HZ=100, N_LED=16).
module tb_led_pattern_engine;

    logic        clk;
    logic        rst;
    logic        en;
    logic        step;
    logic [2:0]  mode;
    logic [1:0]  speed;
    logic [15:0] led;
    logic        wrap;
`ifdef LED_PWM_EN
    logic [3:0]  bright;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state: advances since the last seed, cycles since last tick.
    logic [2:0]  m_mode;
    int          m_k;
    int          m_el;
    logic        m_sprev;
    logic        m_wrap;
    int          m_pwm;

    led_pattern_engine #(
        .N_LED    (16),
        .CLK_HZ   (100),
        .RATE0_HZ (1),
        .RATE1_HZ (2),
        .RATE2_HZ (5),
        .RATE3_HZ (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .step  (step),
        .mode  (mode),
        .speed (speed),
`ifdef LED_PWM_EN
        .bright(bright),
`endif
        .led   (led),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd0: return 100;
            2'd1: return 50;
            2'd2: return 20;
            default: return 10;
        endcase
    endfunction

    // Pattern after k advances from the seed, from the pattern definitions.
    function automatic logic [15:0] exp_pat(input logic [2:0] m, input int k);
        int j;
        int idx;
        case (m)
            3'd0: return 16'h8000 >> (k % 16);
            3'd1: return 16'h0001 << (k % 16);
            3'd2: begin j = k % 8; return (16'h0100 << j) | (16'h0080 >> j); end
            3'd3: begin j = k % 8; return (16'h8000 >> j) | (16'h0001 << j); end
            3'd4: begin
                j   = k % 30;
                idx = (j <= 15) ? 15 - j : j - 15;
                return 16'h0001 << idx;
            end
            3'd5: return (k % 2 == 1) ? 16'h0000 : 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    // Wrap on the advance that lands on advance count k.
    function automatic logic exp_wrap(input logic [2:0] m, input int k);
        case (m)
            3'd0, 3'd1: return (k % 16 == 0);
            3'd2, 3'd3: return (k % 8 == 0);
            3'd4:       return (k % 30 == 1) && (k > 1);
            3'd5:       return (k % 2 == 0);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] pwm_mask();
`ifdef LED_PWM_EN
        return (m_pwm < int'(bright)) ? 16'hFFFF : 16'h0000;
`else
        return 16'hFFFF;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_led(input string tag, input logic [15:0] exp);
        chk(tag, {16'h0, led}, {16'h0, exp & pwm_mask()});
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare.
    task automatic cyc();
        logic tick;
        logic adv;
        @(posedge clk);
        if (!rst) begin
            m_mode  = mode;
            m_k     = 0;
            m_el    = 0;
            m_sprev = 1'b0;
            m_wrap  = 1'b0;
            m_pwm   = 0;
        end else begin
            tick    = en && (m_el >= div_of(speed) - 1);
            adv     = tick || (!en && step && !m_sprev);
            m_sprev = step;
            m_pwm   = (m_pwm + 1) % 16;
            if (mode != m_mode) begin
                m_mode = mode;
                m_k    = 0;
                m_el   = 0;
                m_wrap = 1'b0;
            end else begin
                if (en) m_el = tick ? 0 : m_el + 1;
                if (adv) begin
                    m_k    = m_k + 1;
                    m_wrap = exp_wrap(m_mode, m_k);
                end else begin
                    m_wrap = 1'b0;
                end
            end
        end
        #1;
        chk("model_led", {16'h0, led}, {16'h0, exp_pat(m_mode, m_k) & pwm_mask()});
        chk("model_wrap", {31'h0, wrap}, {31'h0, m_wrap});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int on_cnt;
        rst = 1'b0; en = 1'b1; step = 1'b0; mode = 3'd0; speed = 2'd3;
`ifdef LED_PWM_EN
        bright = 4'd15;
`endif
        // 1: reset and shift right
        run(2);
        rst = 1'b1;
        chk_led("reset_led", 16'h8000);
        chk("reset_wrap", {31'h0, wrap}, 32'h0);
        run(9);
        chk_led("shr_hold9", 16'h8000);
        run(1);
        chk_led("shr_first", 16'h4000);
        run(150);
        chk_led("shr_wrap_led", 16'h8000);
        chk("shr_wrap", {31'h0, wrap}, 32'h1);
        run(1);
        chk("shr_wrap_pulse", {31'h0, wrap}, 32'h0);

        // 2: out then in
        mode = 3'd2;
        run(1);  chk_led("out_seed", 16'h0180);
        run(10); chk_led("out_1", 16'h0240);
        run(10); chk_led("out_2", 16'h0420);
        run(50); chk_led("out_7", 16'h8001);
        run(10); chk_led("out_wrap_led", 16'h0180);
        chk("out_wrap", {31'h0, wrap}, 32'h1);
        mode = 3'd3;
        run(1);  chk_led("in_seed", 16'h8001);
        chk("in_seed_nowrap", {31'h0, wrap}, 32'h0);
        run(10); chk_led("in_1", 16'h4002);
        run(60); chk_led("in_7", 16'h0180);
        run(10); chk_led("in_wrap_led", 16'h8001);
        chk("in_wrap", {31'h0, wrap}, 32'h1);

        // 3: bounce
        mode = 3'd4;
        run(1);   chk_led("bnc_seed", 16'h8000);
        run(150); chk_led("bnc_lsb", 16'h0001);
        run(10);  chk_led("bnc_turn", 16'h0002);
        chk("bnc_turn_nowrap", {31'h0, wrap}, 32'h0);
        run(140); chk_led("bnc_msb", 16'h8000);
        run(10);  chk_led("bnc_wrap_led", 16'h4000);
        chk("bnc_wrap", {31'h0, wrap}, 32'h1);

        // 4: pause with single-step
        en = 1'b0; mode = 3'd1;
        run(1); chk_led("step_seed", 16'h0001);
        for (int p = 0; p < 4; p++) begin
            step = 1'b1; run(3);
            step = 1'b0; run(3);
        end
        chk_led("step_x4", 16'h0010);
        step = 1'b1; run(20);
        step = 1'b0; run(1);
        chk_led("step_held", 16'h0020);
        en = 1'b1;
        for (int p = 0; p < 9; p++) begin
            step = p[0] ? 1'b0 : 1'b1;
            run(1);
        end
        step = 1'b0;
        chk_led("step_ignored", 16'h0020);
        run(1); chk_led("run_after_step", 16'h0040);

        // 5: mode change coincident with a tick, blink, mid-run reset
        mode = 3'd0;
        run(1); chk_led("m5_shr_seed", 16'h8000);
        run(9);
        mode = 3'd5;
        run(1); chk_led("m5_blink_seed", 16'hFFFF);
        chk("m5_nowrap", {31'h0, wrap}, 32'h0);
        run(10); chk_led("blink_off", 16'h0000);
        run(10); chk_led("blink_on", 16'hFFFF);
        chk("blink_wrap", {31'h0, wrap}, 32'h1);
        run(10); chk_led("blink_off2", 16'h0000);
        rst = 1'b0;
        run(1); chk_led("midrun_reset", 16'hFFFF);
        rst = 1'b1;

`ifdef LED_PWM_EN
        // 6: brightness
        en = 1'b0; bright = 4'd4;
        run(1);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            run(1);
            if (led == 16'hFFFF) on_cnt++;
        end
        chk("pwm_b4", on_cnt, 4);
        bright = 4'd0;
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            run(1);
            if (led != 16'h0000) on_cnt++;
        end
        chk("pwm_b0", on_cnt, 0);
        bright = 4'd15;
`else
        on_cnt = 0;
`endif

        // Randomised run against the model
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0)  en = ~en;
            if ($urandom_range(0, 99) == 0)  speed = 2'($urandom_range(0, 3));
            step = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 999) != 0);
`ifdef LED_PWM_EN
            if ($urandom_range(0, 99) == 0) bright = 4'($urandom_range(0, 15));
`endif
            run(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
